// File: rtl/markov_note_generator.sv
// Markov note generator: walks a transition table and emits count-weighted random notes.
// Each note needs a SUM scan, a rejection-sampled DRAW, a SELECT rescan, and an EMIT handshake.
module markov_note_generator #(
    parameter int          NOTE_W    = 7,
    parameter int          CNT_W     = 8,
    parameter int          ADDR_W    = 6,
    parameter int          LEN_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NOTE_W-1:0] seed_note,
    input  logic [LEN_W-1:0]  length,
    input  logic [ADDR_W:0]   tbl_len,
    output logic              tbl_rd_en,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [NOTE_W-1:0] tbl_prev,
    input  logic [NOTE_W-1:0] tbl_next,
    input  logic [CNT_W-1:0]  tbl_count,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    input  logic              note_ready,
    output logic              busy,
    output logic              done,
    output logic              dead_end
);
    localparam int          SUM_W = CNT_W + ADDR_W;
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {S_IDLE, S_SUM, S_DRAW, S_SELECT, S_EMIT, S_FINISH} state_t;
    state_t r_state, w_state_nx;

    logic [15:0]       r_lfsr;
    logic [NOTE_W-1:0] r_cur, r_nxt;
    logic [LEN_W-1:0]  r_rem;
    logic [ADDR_W:0]   r_tbl_len, r_addr;
    logic              r_vld, r_busy, r_dead;
    logic [SUM_W-1:0]  r_sum, r_r;

    logic              w_scan_issue, w_match, w_accept, w_hit;
    logic [SUM_W-1:0]  w_cnt, w_sum_nx, w_mask, w_draw;

    assign w_scan_issue = (r_addr < r_tbl_len);
    assign w_match      = r_vld && (tbl_prev == r_cur);
    assign w_cnt        = SUM_W'(tbl_count);
    assign w_sum_nx     = r_sum + (w_match ? w_cnt : '0);
    assign w_draw       = r_lfsr[SUM_W-1:0] & w_mask;
    assign w_accept     = (w_draw < r_sum);
    assign w_hit        = (r_state == S_SELECT) && w_match && (r_r < w_cnt);

    // Smear total-1 rightwards so the mask is the smallest all-ones value covering it.
    always_comb begin
        w_mask = r_sum - SUM_W'(1);
        for (int unsigned i = 1; i < SUM_W; i = i * 2) begin
            w_mask = w_mask | (w_mask >> i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nx = (length == '0) ? S_FINISH : S_SUM;
            S_SUM:    if (!w_scan_issue) w_state_nx = (w_sum_nx == '0) ? S_FINISH : S_DRAW;
            S_DRAW:   if (w_accept) w_state_nx = S_SELECT;
            S_SELECT: begin
                if (w_hit)              w_state_nx = S_EMIT;
                else if (!w_scan_issue) w_state_nx = S_FINISH;
            end
            S_EMIT:   if (note_ready) w_state_nx = (r_rem == LEN_W'(1)) ? S_FINISH : S_SUM;
            S_FINISH: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tbl_rd_en  = 1'b0;
        note_valid = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_SUM, S_SELECT: tbl_rd_en  = w_scan_issue;
            S_EMIT:          note_valid = 1'b1;
            S_FINISH:        done       = 1'b1;
            default:         ;
        endcase
    end

    assign tbl_addr = r_addr[ADDR_W-1:0];
    assign note_out = r_nxt;
    assign busy     = r_busy;
    assign dead_end = r_dead;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr    <= SEED;
            r_cur     <= '0;
            r_nxt     <= '0;
            r_rem     <= '0;
            r_tbl_len <= '0;
            r_addr    <= '0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            r_dead    <= 1'b0;
            r_sum     <= '0;
            r_r       <= '0;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            r_vld  <= tbl_rd_en;
            if (tbl_rd_en) r_addr <= r_addr + 1'b1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cur     <= seed_note;
                    r_rem     <= length;
                    r_tbl_len <= tbl_len;
                    r_dead    <= 1'b0;
                    r_busy    <= 1'b1;
                    r_addr    <= '0;
                    r_sum     <= '0;
                end
                S_SUM: begin
                    r_sum <= w_sum_nx;
                    if (!w_scan_issue && w_sum_nx == '0) r_dead <= 1'b1;
                end
                S_DRAW: if (w_accept) begin
                    r_r    <= w_draw;
                    r_addr <= '0;
                end
                S_SELECT: begin
                    if (w_hit)        r_nxt <= tbl_next;
                    else if (w_match) r_r   <= r_r - w_cnt;
                    if (!w_hit && !w_scan_issue) r_dead <= 1'b1;
                end
                S_EMIT: if (note_ready) begin
                    r_cur  <= r_nxt;
                    r_rem  <= r_rem - 1'b1;
                    r_addr <= '0;
                    r_sum  <= '0;
                end
                S_FINISH: r_busy <= 1'b0;
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_markov_note_generator.sv
// Directed bench for markov_note_generator: table RAM model, note-legality model, handshake checks.
module tb_markov_note_generator;
    logic       clk = 1'b0;
    logic       reset, start, note_ready;
    logic [6:0] seed_note, tbl_prev, tbl_next, note_out;
    logic [7:0] length, tbl_count;
    logic [6:0] tbl_len;
    logic [5:0] tbl_addr;
    logic       tbl_rd_en, note_valid, busy, done, dead_end;

    markov_note_generator #(.NOTE_W(7), .CNT_W(8), .ADDR_W(6), .LEN_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .seed_note(seed_note), .length(length),
        .tbl_len(tbl_len), .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_prev(tbl_prev),
        .tbl_next(tbl_next), .tbl_count(tbl_count), .note_out(note_out), .note_valid(note_valid),
        .note_ready(note_ready), .busy(busy), .done(done), .dead_end(dead_end)
    );

    always #5 clk = ~clk;

    logic [6:0] t_prev [64];
    logic [6:0] t_next [64];
    logic [7:0] t_cnt  [64];

    always @(posedge clk) begin
        if (tbl_rd_en) begin
            tbl_prev  <= t_prev[tbl_addr];
            tbl_next  <= t_next[tbl_addr];
            tbl_count <= t_cnt[tbl_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cur_m, n_valid, cnt7, cnt9, cnt_other;
    int got[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 64; i++) begin
            t_prev[i] = '0; t_next[i] = '0; t_cnt[i] = '0;
        end
    endtask

    task automatic put(input int idx, input int p, input int n, input int c);
        t_prev[idx] = 7'(p); t_next[idx] = 7'(n); t_cnt[idx] = 8'(c);
    endtask

    // Successors of a note reachable with nonzero count among the first tbl_len entries.
    task automatic succ(input int cur, input int note, output int is_legal, output int n, output int uniq);
        is_legal = 0; n = 0; uniq = -1;
        for (int i = 0; i < int'(tbl_len); i++) begin
            if (int'(t_prev[i]) == cur && t_cnt[i] != 0) begin
                n++;
                uniq = int'(t_next[i]);
                if (int'(t_next[i]) == note) is_legal = 1;
            end
        end
    endtask

    initial begin
        int pv = 0, pr = 0, pn = 0, leg, ns, un;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (pv == 1 && pr == 0) begin
                    chk("hold_valid", int'(note_valid), 1);
                    chk("hold_note", int'(note_out), pn);
                end
                if (note_valid) begin
                    n_valid++;
                    succ(cur_m, int'(note_out), leg, ns, un);
                    chk("legal_note", leg, 1);
                    if (ns == 1) chk("model_note", int'(note_out), un);
                    if (note_ready) begin
                        got.push_back(int'(note_out));
                        if (cur_m == 4) begin
                            if (note_out == 7)      cnt7++;
                            else if (note_out == 9) cnt9++;
                            else                    cnt_other++;
                        end
                        cur_m = int'(note_out);
                    end
                end
                pv = int'(note_valid); pr = int'(note_ready); pn = int'(note_out);
            end else begin
                pv = 0;
            end
        end
    end

    task automatic run_seq(input int sd, input int len, input int tl, input int budget, output int dflag);
        int seen = 0;
        got.delete();
        n_valid   = 0;
        cur_m     = sd;
        seed_note = 7'(sd);
        length    = 8'(len);
        tbl_len   = 7'(tl);
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("done_within_budget", seen, 1);
        dflag = int'(dead_end);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(note_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_dead"}, int'(dead_end), 0);
        chk({tag, "_rden"}, int'(tbl_rd_en), 0);
        chk({tag, "_note"}, int'(note_out), 0);
    endtask

    initial begin
        int d, ok, phase;
        int exp6[6] = '{2, 3, 1, 2, 3, 1};
        reset = 1'b0; start = 1'b0; note_ready = 1'b1;
        seed_note = '0; length = '0; tbl_len = '0;
        cnt7 = 0; cnt9 = 0; cnt_other = 0;
        clear_tbl();
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();
        chk_all_zero("post_reset");

        // single transition
        put(0, 3, 5, 4);
        run_seq(3, 1, 1, 100, d);
        chk("single_len", got.size(), 1);
        if (got.size() > 0) chk("single_note", got[0], 5);
        chk("single_dead", d, 0);
        chk("single_busy_clear", int'(busy), 0);

        // three-note cycle
        clear_tbl();
        put(0, 1, 2, 1); put(1, 2, 3, 1); put(2, 3, 1, 1);
        run_seq(1, 6, 3, 300, d);
        chk("chain_len", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("chain_note", got[i], exp6[i]);
        chk("chain_dead", d, 0);

        // no outgoing transition
        run_seq(10, 5, 3, 100, d);
        chk("dead_valids", n_valid, 0);
        chk("dead_flag", d, 1);
        repeat (3) step();
        chk("dead_sticky", int'(dead_end), 1);
        chk("dead_no_done", int'(done), 0);

        // consumer stall with an ignored start
        got.delete();
        cur_m = 1; note_ready = 1'b0;
        seed_note = 7'd1; length = 8'd3; tbl_len = 7'd3;
        start = 1'b1; step(); start = 1'b0;
        chk("dead_clear_on_start", int'(dead_end), 0);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            if (note_valid) begin ok = 1; break; end
            step();
        end
        chk("stall_valid_seen", ok, 1);
        chk("stall_first_note", int'(note_out), 2);
        seed_note = 7'd9; length = 8'd7;
        for (int k = 0; k < 20; k++) begin
            start = (k == 10);
            step();
        end
        start = 1'b0;
        chk("stall_still_valid", int'(note_valid), 1);
        chk("stall_busy", int'(busy), 1);
        note_ready = 1'b1;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        chk("stall_done", ok, 1);
        step();
        chk("stall_len", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("stall_note", got[i], exp6[i]);

        // zero-length sequence
        run_seq(5, 0, 3, 10, d);
        chk("len0_valids", n_valid, 0);
        chk("len0_dead", d, 0);

        // weighted split, zero-count entry never taken
        clear_tbl();
        put(0, 4, 7, 3); put(1, 4, 9, 1); put(2, 4, 11, 0); put(3, 7, 4, 1); put(4, 9, 4, 1);
        for (int r = 0; r < 16; r++) begin
            run_seq(4, 250, 5, 6000, d);
            chk("dist_len", got.size(), 250);
            chk("dist_dead", d, 0);
        end
        chk("dist_draws", cnt7 + cnt9, 2000);
        chk("dist_zero_cnt", cnt_other, 0);
        chk("dist_75pct", int'(cnt7 * 1000 >= 720 * 2000 && cnt7 * 1000 <= 780 * 2000), 1);

        // reset during SELECT (second rd_en burst after start)
        clear_tbl();
        put(0, 1, 2, 1); put(1, 2, 3, 1); put(2, 3, 1, 1);
        seed_note = 7'd1; length = 8'd4; tbl_len = 7'd3; cur_m = 1;
        start = 1'b1; step(); start = 1'b0;
        phase = 0; ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (phase == 0 && tbl_rd_en) phase = 1;
            else if (phase == 1 && !tbl_rd_en) phase = 2;
            else if (phase == 2 && tbl_rd_en) begin ok = 1; break; end
        end
        chk("select_reached", ok, 1);
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        step();
        chk_all_zero("abort_next");
        reset = 1'b1;
        step();
        run_seq(2, 2, 3, 200, d);
        chk("fresh_len", got.size(), 2);
        if (got.size() == 2) begin
            chk("fresh_note0", got[0], 3);
            chk("fresh_note1", got[1], 1);
        end
        chk("fresh_dead", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
